branch_resolver: RTL and testbench

Resolves branch predictions in order and drives recovery on a misprediction. Sits at the consumer (pop) end of the 11-bit alternate-PC backup FIFO: the fetch side pushes the non-predicted PC there on every prediction, and this block pops it once the branch outcome is known. On a misprediction it redirects fetch to the popped PC, clears the backup FIFO and flushes the pipeline.

---
 rtl/branch_resolver.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// In-order branch resolution with misprediction recovery, consuming the alternate-PC backup FIFO.
// Optional BRANCH_RESOLVER_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolver #(
    parameter int unsigned PC_W         = 11,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    output logic                         pred_full,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         res_ready,
    output logic                         fifo_pop,
    output logic                         fifo_clear,
    input  logic [PC_W-1:0]              fifo_P,
    output logic                         redirect_valid,
    output logic [PC_W-1:0]              redirect_pc,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
`ifdef BRANCH_RESOLVER_STATS_EN
    output logic [15:0]                  stat_resolved,
    output logic [15:0]                  stat_mispredicts,
`endif
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POP      = 3'd1,
        CHECK    = 3'd2,
        REDIRECT = 3'd3,
        FLUSH    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   dir_q, dir_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               mispredict_q, mispredict_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;
    logic [PC_W-1:0]    rpc_d;
    logic               ovf_d, unf_d;
    logic               pop_d, clr_d, rdv_d, flush_d;
    logic               push_acc, push_ok, pop_dec;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pred_full = (outstanding == CNT_W'(DEPTH));
    assign res_ready = (state_q == IDLE);

    // Next-state, queue bookkeeping and registered-output decode
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = outstanding;
        mispredict_d = mispredict_q;
        fcnt_d       = fcnt_q;
        rpc_d        = redirect_pc;
        ovf_d        = overflow;
        unf_d        = underflow;

        push_acc = pred_valid && (state_q == IDLE || state_q == POP || state_q == CHECK);
        push_ok  = push_acc && !pred_full;
        pop_dec  = (state_q == POP);

        if (push_acc && pred_full) begin
            ovf_d = 1'b1;
        end
        if (push_ok) begin
            dir_d[wr_ptr_q] = pred_taken;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        if (push_ok && !pop_dec) begin
            cnt_d = outstanding + CNT_W'(1);
        end else if (!push_ok && pop_dec) begin
            cnt_d = outstanding - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (res_valid) begin
                    if (outstanding != '0) begin
                        state_d      = POP;
                        mispredict_d = (res_taken != dir_q[rd_ptr_q]);
                        rd_ptr_d     = ptr_inc(rd_ptr_q);
                    end else begin
                        unf_d = 1'b1;
                    end
                end
            end
            POP: state_d = CHECK;
            CHECK: begin
                if (mispredict_q) begin
                    state_d = REDIRECT;
                    rpc_d   = fifo_P;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                state_d  = FLUSH;
                cnt_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                fcnt_d   = FC_W'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pop_d   = (state_d == POP);
        clr_d   = (state_d == REDIRECT);
        rdv_d   = (state_d == REDIRECT);
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            dir_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            outstanding    <= '0;
            mispredict_q   <= 1'b0;
            fcnt_q         <= '0;
            redirect_pc    <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            fifo_pop       <= 1'b0;
            fifo_clear     <= 1'b0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            outstanding    <= cnt_d;
            mispredict_q   <= mispredict_d;
            fcnt_q         <= fcnt_d;
            redirect_pc    <= rpc_d;
            overflow       <= ovf_d;
            underflow      <= unf_d;
            fifo_pop       <= pop_d;
            fifo_clear     <= clr_d;
            redirect_valid <= rdv_d;
            flush          <= flush_d;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    // Saturating event counters: one resolve per CHECK, one mispredict per REDIRECT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (state_q == CHECK && stat_resolved != 16'hFFFF) begin
                stat_resolved <= stat_resolved + 16'd1;
            end
            if (state_q == REDIRECT && stat_mispredicts != 16'hFFFF) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vector table, reset corner sequences and a randomized run
// against a phase-based reference model with a registered-output backup FIFO.
module tb_branch_resolver;

    localparam int unsigned PC_W  = 11;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FC    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              pred_valid = 1'b0, pred_taken = 1'b0;
    logic              res_valid = 1'b0, res_taken = 1'b0;
    logic [PC_W-1:0]   fifo_P = '0;
    logic              pred_full, res_ready, fifo_pop, fifo_clear, redirect_valid, flush;
    logic              overflow, underflow;
    logic [PC_W-1:0]   redirect_pc;
    logic [3:0]        outstanding;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0]       stat_resolved, stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolver #(.PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_full(pred_full),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .fifo_pop(fifo_pop), .fifo_clear(fifo_clear), .fifo_P(fifo_P),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .outstanding(outstanding),
`ifdef BRANCH_RESOLVER_STATS_EN
        .stat_resolved(stat_resolved), .stat_mispredicts(stat_mispredicts),
`endif
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv, pt, rv, rt;
        logic [10:0] fp;
        logic [22:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic        t_ovf = 1'b0, t_unf = 1'b0;
    logic [10:0] t_rpc = '0;

    // {pop, clear, redirect, flush, ready, full, ovf, unf, outstanding[3:0], redirect_pc[10:0]}
    function automatic logic [22:0] mk(input logic pop, clr, rdv, fl, rdy, full, ovf, unf,
                                       input int o, input logic [10:0] rpc);
        return {pop, clr, rdv, fl, rdy, full, ovf, unf, 4'(o), rpc};
    endfunction

    function automatic logic [22:0] act_vec();
        return {fifo_pop, fifo_clear, redirect_valid, flush, res_ready, pred_full,
                overflow, underflow, outstanding, redirect_pc};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic pv, pt, rv, rt, input logic [10:0] fp,
                       input logic pop, clr, rdv, fl, rdy, input int o);
        vec_t v;
        v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt; v.fp = fp;
        v.exp = mk(pop, clr, rdv, fl, rdy, o == DEPTH, t_ovf, t_unf, o, t_rpc);
        tbl.push_back(v);
    endtask

    task automatic cyc(input logic pv, pt, rv, rt);
        @(negedge clk);
        pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pred_valid = 0; res_valid = 0;
        rst_n = 1'b0;
        #1;
        check("reset_vals", 32'(act_vec()), 32'(mk(0,0,0,0,1,0,0,0,0,0)));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: m_k counts cycles since a resolution was accepted (-1 when idle)
    int          m_k, m_cnt, m_sres, m_smis;
    logic        m_mis, m_ovf, m_unf;
    logic [10:0] m_rpc, m_fp;
    logic        m_dirq[$];
    logic [10:0] m_pcq[$];

    task automatic model_reset();
        m_k = -1; m_cnt = 0; m_sres = 0; m_smis = 0;
        m_mis = 0; m_ovf = 0; m_unf = 0; m_rpc = '0; m_fp = '0;
        m_dirq.delete(); m_pcq.delete();
    endtask

    task automatic model_step();
        int  k   = m_k;
        int  cnt = m_cnt;
        bit  accept_pred = !(m_mis && k >= 2);
        bit  full = (m_cnt == DEPTH);
        if (k == -1) begin
            if (res_valid) begin
                if (m_cnt > 0) begin
                    m_mis = (res_taken != m_dirq[0]);
                    void'(m_dirq.pop_front());
                    m_k = 0;
                end else begin
                    m_unf = 1;
                end
            end
        end else begin
            if (k == 0) begin
                cnt--;
                m_fp = (m_pcq.size() > 0) ? m_pcq.pop_front() : 11'h0;
            end
            if (k == 1) begin
                if (m_sres < 65535) m_sres++;
                if (m_mis) m_rpc = fifo_P;
            end
            if (m_mis && k == 2) begin
                cnt = 0;
                m_dirq.delete();
                m_pcq.delete();
                if (m_smis < 65535) m_smis++;
            end
            m_k = k + 1;
            if (!m_mis && k == 1) m_k = -1;
            if (m_mis && k == 2 + int'(FC)) m_k = -1;
        end
        if (pred_valid && accept_pred) begin
            if (full) begin
                m_ovf = 1;
            end else begin
                m_dirq.push_back(pred_taken);
                m_pcq.push_back(11'($urandom));
                cnt++;
            end
        end
        m_cnt = cnt;
    endtask

    function automatic logic [22:0] model_vec();
        return mk(m_k == 0, m_mis && m_k == 2, m_mis && m_k == 2,
                  m_mis && m_k >= 3 && m_k <= 2 + int'(FC), m_k == -1,
                  m_cnt == DEPTH, m_ovf, m_unf, m_cnt, m_rpc);
    endfunction

    initial begin
        logic [7:0] pat;
        int         n;
        pat = 8'b1001_0110;

        // Correct resolutions of T,N,T
        add(1,1,0,0,0, 0,0,0,0,1, 1);
        add(1,0,0,0,0, 0,0,0,0,1, 2);
        add(1,1,0,0,0, 0,0,0,0,1, 3);
        add(0,0,1,1,0, 1,0,0,0,0, 3);
        add(0,0,0,0,0, 0,0,0,0,0, 2);
        add(0,0,0,0,0, 0,0,0,0,1, 2);
        add(0,0,1,0,0, 1,0,0,0,0, 2);
        add(0,0,0,0,0, 0,0,0,0,0, 1);
        add(0,0,0,0,0, 0,0,0,0,1, 1);
        add(0,0,1,1,0, 1,0,0,0,0, 1);
        add(0,0,0,0,0, 0,0,0,0,0, 0);
        add(0,0,0,0,0, 0,0,0,0,1, 0);
        // Mispredict with wrong-path predictions during REDIRECT/FLUSH
        add(1,1,0,0,0, 0,0,0,0,1, 1);
        add(0,0,1,0,0, 1,0,0,0,0, 1);
        add(0,0,0,0,0, 0,0,0,0,0, 0);
        t_rpc = 11'h2A4;
        add(0,0,0,0,11'h2A4, 0,1,1,0,0, 0);
        add(1,1,0,0,0, 0,0,0,1,0, 0);
        add(1,0,0,0,0, 0,0,0,1,0, 0);
        add(1,1,0,0,0, 0,0,0,0,1, 0);
        // Push coinciding with fifo_pop
        add(1,0,0,0,0, 0,0,0,0,1, 1);
        add(0,0,1,0,0, 1,0,0,0,0, 1);
        add(1,1,0,0,0, 0,0,0,0,0, 1);
        add(0,0,0,0,0, 0,0,0,0,1, 1);
        add(0,0,1,1,0, 1,0,0,0,0, 1);
        add(0,0,0,0,0, 0,0,0,0,0, 0);
        add(0,0,0,0,0, 0,0,0,0,1, 0);
        // Underflow
        t_unf = 1'b1;
        add(0,0,1,0,0, 0,0,0,0,1, 0);
        // Fill to DEPTH, overflow, then drain across pointer wrap
        for (int j = 0; j < 8; j++) add(1,pat[j],0,0,0, 0,0,0,0,1, j + 1);
        t_ovf = 1'b1;
        add(1,1,0,0,0, 0,0,0,0,1, 8);
        for (int j = 0; j < 8; j++) begin
            add(0,0,1,pat[j],0, 1,0,0,0,0, 8 - j);
            add(0,0,0,0,0,      0,0,0,0,0, 7 - j);
            add(0,0,0,0,0,      0,0,0,0,1, 7 - j);
        end

        #2;
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            pred_valid = tbl[i].pv; pred_taken = tbl[i].pt;
            res_valid  = tbl[i].rv; res_taken  = tbl[i].rt;
            fifo_P     = tbl[i].fp;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(act_vec()), 32'(tbl[i].exp));
        end

        // Reset while in POP
        cyc(1,1,0,0);
        cyc(0,0,1,1);
        check("pop_before_rst", 32'(fifo_pop), 32'd1);
        do_reset();

        // Reset while in FLUSH
        fifo_P = 11'h155;
        cyc(1,1,0,0);
        cyc(0,0,1,0);
        n = 0;
        while (!flush && n < 10) begin
            cyc(0,0,0,0);
            n++;
        end
        check("flush_seen", 32'(flush), 32'd1);
        check("rpc_captured", 32'(redirect_pc), 32'h155);
        do_reset();
`ifdef BRANCH_RESOLVER_STATS_EN
        check("stat_res_rst", 32'(stat_resolved), 32'd0);
        check("stat_mis_rst", 32'(stat_mispredicts), 32'd0);
        cyc(1,1,0,0);
        cyc(1,1,0,0);
        cyc(0,0,1,1);
        for (int j = 0; j < 3; j++) cyc(0,0,0,0);
        cyc(0,0,1,0);
        for (int j = 0; j < 6; j++) cyc(0,0,0,0);
        check("stat_res_2", 32'(stat_resolved), 32'd2);
        check("stat_mis_1", 32'(stat_mispredicts), 32'd1);
`endif

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            pred_valid = ($urandom_range(0, 1) == 1);
            pred_taken = 1'($urandom);
            res_valid  = ($urandom_range(0, 2) == 0);
            res_taken  = 1'($urandom);
            fifo_P     = m_fp;
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("rand%0d", c), 32'(act_vec()), 32'(model_vec()));
        end
`ifdef BRANCH_RESOLVER_STATS_EN
        check("rand_stat_res", 32'(stat_resolved), 32'(m_sres));
        check("rand_stat_mis", 32'(stat_mispredicts), 32'(m_smis));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
